// File: rtl/skew_feeder.sv
// Operand skew buffer: lane i delays accepted rows by BASE_DELAY + i*SKEW_STEP enabled cycles,
// then flushes zeros and pulses done. Optional per-lane valid tags: define SKEW_FEEDER_LANE_VLD_EN.
module skew_feeder #(
    parameter int BITS       = 8,
    parameter int DIM        = 8,
    parameter int BASE_DELAY = 8,
    parameter int SKEW_STEP  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIM*BITS-1:0]        Bin,
    output logic [DIM*BITS-1:0]        Bout,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DIM+1)-1:0]   row_count
`ifdef SKEW_FEEDER_LANE_VLD_EN
    ,
    output logic [DIM-1:0]             lane_vld
`endif
);

    localparam int D_MAX = BASE_DELAY + (DIM - 1) * SKEW_STEP;
    localparam int RW    = $clog2(DIM + 1);
    localparam int FW    = $clog2(D_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [FW-1:0]   flush_cnt;
    logic            accept;
    logic            last_row;
    logic            flush_last;

    // Handshake: a row transfers on a rising edge where en & in_valid & in_ready;
    // in_ready depends on state only, so in_valid may be held without combinational loops.
    assign last_row   = (row_count == RW'(DIM - 1));
    assign flush_last = (flush_cnt == FW'(D_MAX - 1));

    always_comb begin
        state_nx = state;
        in_ready = (state == LOAD);
        busy     = (state != IDLE);
        accept   = en & in_valid & in_ready;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (accept && last_row) state_nx = FLUSH;
            FLUSH:   if (flush_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_count <= '0;
            flush_cnt <= '0;
            done      <= 1'b0;
        end else begin
            // done is a plain one-clock pulse; it does not wait for en to drop it.
            done <= en && (state == FLUSH) && flush_last;
            if (en) begin
                state <= state_nx;
                if (state == IDLE && start)
                    row_count <= '0;
                else if (accept)
                    row_count <= row_count + RW'(1);
                if (state == FLUSH && !flush_last)
                    flush_cnt <= flush_cnt + FW'(1);
                else
                    flush_cnt <= '0;
            end
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        localparam int D = BASE_DELAY + i * SKEW_STEP;

        logic [BITS-1:0] sr [D];

        // Non-accepting edges inject zeros so bubbles and the flush drain cleanly.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < D; j++) sr[j] <= '0;
            end else if (en) begin
                sr[0] <= accept ? Bin[i*BITS +: BITS] : '0;
                for (int j = 1; j < D; j++) sr[j] <= sr[j-1];
            end
        end

        assign Bout[i*BITS +: BITS] = sr[D-1];

`ifdef SKEW_FEEDER_LANE_VLD_EN
        logic vsr [D];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < D; j++) vsr[j] <= 1'b0;
            end else if (en) begin
                vsr[0] <= accept;
                for (int j = 1; j < D; j++) vsr[j] <= vsr[j-1];
            end
        end

        assign lane_vld[i] = vsr[D-1];
`endif
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder with DIM=4, BITS=8, BASE_DELAY=4, SKEW_STEP=1 (D = 4,5,6,7).
// Lane outputs are checked every clock against the expected wavefront built from accepted rows.
module tb_skew_feeder;

    localparam int BITS = 8;
    localparam int DIM  = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [DIM*BITS-1:0]   Bin;
    logic [DIM*BITS-1:0]   Bout;
    logic                  busy;
    logic                  done;
    logic [2:0]            row_count;
`ifdef SKEW_FEEDER_LANE_VLD_EN
    logic [DIM-1:0]        lane_vld;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int en_edge  = 0;
    int cycle    = 0;
    int start_cycle = 0;
    int n_acc    = 0;
    int acc_edge [16];
    int acc_row  [16];

    skew_feeder #(
        .BITS(BITS), .DIM(DIM), .BASE_DELAY(4), .SKEW_STEP(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Bin       (Bin),
        .Bout      (Bout),
        .busy      (busy),
        .done      (done),
        .row_count (row_count)
`ifdef SKEW_FEEDER_LANE_VLD_EN
        ,
        .lane_vld  (lane_vld)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lane(input int i);
        return Bout[i*BITS +: BITS];
    endfunction

    // Row r accepted on enabled edge a shows on lane i after enabled edge a + (4+i) - 1.
    function automatic logic [7:0] exp_lane(input int i);
        logic [7:0] v;
        v = 8'h00;
        for (int r = 0; r < n_acc; r++)
            if (acc_edge[r] + 3 + i == en_edge) v = 8'(16 * acc_row[r] + i + 1);
        return v;
    endfunction

    function automatic logic exp_vld(input int i);
        logic v;
        v = 1'b0;
        for (int r = 0; r < n_acc; r++)
            if (acc_edge[r] + 3 + i == en_edge) v = 1'b1;
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        logic e;
        e = en;
        @(posedge clk);
        #1;
        cycle++;
        if (e) en_edge++;
        for (int i = 0; i < DIM; i++) begin
            check($sformatf("bout%0d_e%0d", i, en_edge), 32'(lane(i)), 32'(exp_lane(i)));
`ifdef SKEW_FEEDER_LANE_VLD_EN
            check($sformatf("vld%0d_e%0d", i, en_edge), 32'(lane_vld[i]), 32'(exp_vld(i)));
`endif
        end
    endtask

    task automatic start_matrix();
        n_acc = 0;
        start_cycle = cycle;
        en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(in_ready), 1);
        check("start_row_count", 32'(row_count), 0);
    endtask

    task automatic send_row(input int r);
        check($sformatf("ready_row%0d", r), 32'(in_ready), 1);
        en = 1'b1;
        for (int i = 0; i < DIM; i++) Bin[i*BITS +: BITS] = 8'(16 * r + i + 1);
        in_valid = 1'b1;
        acc_edge[n_acc] = en_edge + 1;
        acc_row[n_acc]  = r;
        n_acc++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_matrix(input int exp_len);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            check("busy_flush", 32'(busy), 1);
            tick();
            n++;
        end
        check("done_seen", 32'(done), 1);
        check("done_latency", 32'(cycle - start_cycle), 32'(exp_len));
        check("busy_at_done", 32'(busy), 0);
        check("ready_at_done", 32'(in_ready), 0);
        check("row_count_at_done", 32'(row_count), 4);
        for (int i = 0; i < DIM; i++) check($sformatf("drained%0d", i), 32'(lane(i)), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        Bin      = '0;

        // 1: reset and idle
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_row_count", 32'(row_count), 0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        Bin = {4{8'h5A}};
        tick();
        tick();
        check("idle_ready", 32'(in_ready), 0);
        check("idle_busy", 32'(busy), 0);
        in_valid = 1'b0;
        en = 1'b0;
        start = 1'b1;
        tick();
        check("frozen_start_busy", 32'(busy), 0);
        start = 1'b0;
        en = 1'b1;

        // 2: back-to-back rows; in_valid during flush must be ignored
        start_matrix();
        for (int r = 0; r < 4; r++) begin
            send_row(r);
            check($sformatf("row_count_%0d", r), 32'(row_count), 32'(r + 1));
        end
        check("t2_lane0_k3", 32'(lane(0)), 32'h01);
        check("t2_ready_flush", 32'(in_ready), 0);
        in_valid = 1'b1;
        Bin = {4{8'hEE}};
        tick(); tick(); tick();
        check("t2_lane3_k6", 32'(lane(3)), 32'h04);
        tick(); tick(); tick();
        check("t2_lane3_k9", 32'(lane(3)), 32'h34);
        check("t2_done_early", 32'(done), 0);
        finish_matrix(12);
        in_valid = 1'b0;
        tick();
        check("t2_done_pulse", 32'(done), 0);

        // 3: en low 3 cycles mid-LOAD; start in LOAD/FLUSH ignored
        start_matrix();
        send_row(0);
        send_row(1);
        en = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        Bin = {4{8'hC3}};
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t3_freeze_row_count", 32'(row_count), 2);
            check("t3_freeze_ready", 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        send_row(2);
        send_row(3);
        check("t3_row_count", 32'(row_count), 4);
        finish_matrix(15);
        start = 1'b0;
        tick();
        check("t3_start_in_flush_busy", 32'(busy), 0);
        check("t3_done_pulse", 32'(done), 0);

        // 4: two-cycle bubble between rows 1 and 2
        start_matrix();
        send_row(0);
        send_row(1);
        Bin = {4{8'hAA}};
        tick();
        check("t4_gap_row_count_a", 32'(row_count), 2);
        tick();
        check("t4_gap_row_count_b", 32'(row_count), 2);
        send_row(2);
        check("t4_row_count_3", 32'(row_count), 3);
        send_row(3);
        finish_matrix(14);

        // start in the done cycle is honoured
        n_acc = 0;
        start_cycle = cycle;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_cycle_start_busy", 32'(busy), 1);
        check("done_cycle_start_row_count", 32'(row_count), 0);
        check("done_cycle_done_low", 32'(done), 0);

        // 5: reset mid-matrix, then a clean matrix
        send_row(0);
        send_row(1);
        send_row(2);
        rst_n = 1'b0;
        n_acc = 0;
        #1;
        for (int i = 0; i < DIM; i++) check($sformatf("t5_rst_lane%0d", i), 32'(lane(i)), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_ready", 32'(in_ready), 0);
        check("t5_rst_row_count", 32'(row_count), 0);
        #2;
        rst_n = 1'b1;
        tick();
        start_matrix();
        for (int r = 0; r < 4; r++) send_row(r);
        finish_matrix(12);
        tick();
        check("t5_done_pulse", 32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
